demux1to3_16b: RTL and testbench

//  Inverse of the 3:1 16-bit ALU result mux: steers one 16-bit word to one of three

---
 rtl/demux1to3_16b.sv | 109 ++++++++++
 tb/tb_demux1to3_16b.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/demux1to3_16b.sv
// demux1to3_16b: steers one WIDTH-bit word to one of three registered slots
// (b, c, d) selected by {in1,in0}. Select 00 discards the word.
// Each slot holds one word behind a valid/ready handshake and can be drained
// and refilled on the same edge, so a busy slot never shows a bubble.
// Optional feature: define DROP_CNT_EN to add the saturating drop_cnt output.

// One-entry holding register for a single destination slot.
module demux1to3_16b_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clkpos,
  input  logic             rstn,
  input  logic             fill,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  // A fill wins over a drain, which keeps valid high with the new word.
  // The data register is only written on a fill, so it keeps its last word after a drain.
  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (fill) begin
      q   <= din;
      vld <= 1'b1;
    end else if (vld && rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

module demux1to3_16b #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
`ifdef DROP_CNT_EN
  output logic [CNT_W-1:0] drop_cnt,
`endif
  input  logic             clkpos,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in0,
  input  logic             in1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] b,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] c,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [WIDTH-1:0] d,
  output logic             d_valid,
  input  logic             d_ready
);

  localparam int NS = 3;

  logic [1:0]                sel;
  logic                      accept;
  logic [NS-1:0]             slot_vld;
  logic [NS-1:0]             slot_rdy;
  logic [NS-1:0]             slot_fill;
  logic [NS-1:0][WIDTH-1:0]  slot_q;

  assign sel      = {in1, in0};
  assign slot_rdy = {d_ready, c_ready, b_ready};
  assign accept   = in_valid & in_ready;

  // Only the selected slot can stall the input; the discard leg always accepts.
  always_comb begin
    in_ready = 1'b1;
    if (sel != 2'b00) in_ready = ~slot_vld[sel - 2'd1] | slot_rdy[sel - 2'd1];
  end

  // Slot i takes select code i+1.
  for (genvar i = 0; i < NS; i++) begin : g_slot
    assign slot_fill[i] = accept & (sel == 2'(i + 1));
    demux1to3_16b_slot #(.WIDTH(WIDTH)) u_slot (
      .clkpos (clkpos),
      .rstn   (rstn),
      .fill   (slot_fill[i]),
      .din    (in_data),
      .rdy    (slot_rdy[i]),
      .q      (slot_q[i]),
      .vld    (slot_vld[i])
    );
  end

  assign b       = slot_q[0];
  assign c       = slot_q[1];
  assign d       = slot_q[2];
  assign b_valid = slot_vld[0];
  assign c_valid = slot_vld[1];
  assign d_valid = slot_vld[2];

`ifdef DROP_CNT_EN
  // Count accepted discards, sticking at all-ones rather than wrapping.
  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn)                                      drop_cnt <= '0;
    else if (accept && sel == 2'b00 && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_demux1to3_16b.sv
module tb_demux1to3_16b;

  logic        clkpos = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] in_data = '0;
  logic        in0 = 1'b0, in1 = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] b, c, d;
  logic        b_valid, c_valid, d_valid;
  logic        b_ready = 1'b0, c_ready = 1'b0, d_ready = 1'b0;
`ifdef DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b1;
  logic [15:0] qb[$], qc[$], qd[$];
  int drop_m = 0;

  always #5 clkpos = ~clkpos;

  demux1to3_16b dut (
`ifdef DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .clkpos (clkpos), .rstn (rstn), .in_data (in_data),
    .in0 (in0), .in1 (in1), .in_valid (in_valid), .in_ready (in_ready),
    .b (b), .b_valid (b_valid), .b_ready (b_ready),
    .c (c), .c_valid (c_valid), .c_ready (c_ready),
    .d (d), .d_valid (d_valid), .d_ready (d_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each slot must present exactly the head of its expected queue;
  // a handshake (valid & ready) at the coming edge retires that head.
  always @(negedge clkpos) begin
    if (rstn && mon_en) begin
      chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
      if (b_valid && qb.size() != 0) begin
        chk("b_data", 32'(b), 32'(qb[0]));
        if (b_ready) void'(qb.pop_front());
      end
      chk("c_valid", 32'(c_valid), 32'(qc.size() != 0));
      if (c_valid && qc.size() != 0) begin
        chk("c_data", 32'(c), 32'(qc[0]));
        if (c_ready) void'(qc.pop_front());
      end
      chk("d_valid", 32'(d_valid), 32'(qd.size() != 0));
      if (d_valid && qd.size() != 0) begin
        chk("d_data", 32'(d), 32'(qd[0]));
        if (d_ready) void'(qd.pop_front());
      end
    end
  end

  // One cycle of stimulus: drive after the edge, then after the monitor has
  // retired this edge's drains, predict in_ready and push accepted words.
  task automatic cyc(input bit v, input logic [1:0] s, input logic [15:0] dat,
                     input logic [2:0] rdy);
    bit exp_ir;
    @(posedge clkpos); #1;
    in_valid = v; {in1, in0} = s; in_data = dat; {d_ready, c_ready, b_ready} = rdy;
    @(negedge clkpos); #1;
    case (s)
      2'd1:    exp_ir = (qb.size() == 0);
      2'd2:    exp_ir = (qc.size() == 0);
      2'd3:    exp_ir = (qd.size() == 0);
      default: exp_ir = 1'b1;
    endcase
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    if (v && exp_ir) begin
      case (s)
        2'd1:    qb.push_back(dat);
        2'd2:    qc.push_back(dat);
        2'd3:    qd.push_back(dat);
        default: drop_m = (drop_m == 255) ? 255 : drop_m + 1;
      endcase
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_b", 32'(b), 32'h0);
    chk("rst_c", 32'(c), 32'h0);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_valids", 32'({b_valid, c_valid, d_valid}), 32'h0);
`ifdef DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 32'h0);
`endif
    #10 rstn = 1'b1;

    // Fill b, stalled; a second word for b is refused
    cyc(1'b1, 2'd1, 16'hA5A5, 3'b000);
    cyc(1'b0, 2'd0, 16'h0000, 3'b000);
    chk("t1_b", 32'(b), 32'hA5A5);
    chk("t1_bv", 32'(b_valid), 32'h1);
    chk("t1_cdv", 32'({c_valid, d_valid}), 32'h0);
    cyc(1'b1, 2'd1, 16'hBEEF, 3'b000);
    chk("t1_ir0", 32'(in_ready), 32'h0);
    chk("t1_bhold", 32'(b), 32'hA5A5);

    // Drain and refill b on the same edge: no bubble
    cyc(1'b1, 2'd1, 16'h1234, 3'b001);
    cyc(1'b0, 2'd0, 16'h0000, 3'b000);
    chk("t2_b", 32'(b), 32'h1234);
    chk("t2_bv", 32'(b_valid), 32'h1);

    // b stalled does not block c and d
    cyc(1'b1, 2'd2, 16'h00FF, 3'b000);
    cyc(1'b1, 2'd3, 16'hFF00, 3'b000);
    cyc(1'b0, 2'd0, 16'h0000, 3'b000);
    chk("t3_c", 32'(c), 32'h00FF);
    chk("t3_d", 32'(d), 32'hFF00);
    chk("t3_b", 32'(b), 32'h1234);
    chk("t3_valids", 32'({b_valid, c_valid, d_valid}), 32'h7);

    // Discards: always accepted, no slot touched (all slots are full here)
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 16'(i), 3'b000);
`ifdef DROP_CNT_EN
    chk("drop5", 32'(drop_cnt), 32'(drop_m));
`endif

    // Async reset with all slots full: outputs clear before the next edge
    @(posedge clkpos); #3;
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("t5_valids", 32'({b_valid, c_valid, d_valid}), 32'h0);
    chk("t5_data", 32'({b, c, d}), 32'h0);
    qb.delete(); qc.delete(); qd.delete();
    drop_m = 0;
`ifdef DROP_CNT_EN
    chk("t5_drop", 32'(drop_cnt), 32'h0);
`endif
    #3 rstn = 1'b1;

    // 300 discards: counter saturates, no valid ever rises
    for (int i = 0; i < 300; i++) cyc(1'b1, 2'd0, 16'(i * 7), 3'b000);
`ifdef DROP_CNT_EN
    chk("t4_drop_sat", 32'(drop_cnt), 32'd255);
`endif

    // Random traffic against the scoreboard
    for (int i = 0; i < 4000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          16'($urandom), 3'($urandom));

    // Drain everything and confirm nothing was lost
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, 16'h0000, 3'b111);
    chk("end_qb", 32'(qb.size()), 32'h0);
    chk("end_qc", 32'(qc.size()), 32'h0);
    chk("end_qd", 32'(qd.size()), 32'h0);
`ifdef DROP_CNT_EN
    chk("end_drop", 32'(drop_cnt), 32'(drop_m));
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
